// File: rtl/mmio_uart.sv
// mmio_uart: MMIO register block fronting an 8N1 UART.
// Registers (word offsets): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 DIVISOR.
//
// Handshakes:
//   write: the decoder holds i_mmio_wr_valid with a stable address and data.
//          o_mmio_wr_ready is combinational, and the register update happens
//          on the clock edge where valid && ready are both high.
//   read:  i_mmio_rd_ready with a hit address in IDLE starts a read. The data
//          is registered, and o_mmio_rd_valid is high for exactly one cycle
//          (RESP). If i_mmio_rd_ready is still high in that cycle, the
//          transfer completes and side effects apply (RXDATA clears rx_valid).
//          Otherwise the read is abandoned and has no side effect.
module mmio_uart #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000,
  parameter logic [15:0] CLK_DIV    = 16'd868,
  parameter int          TX_DEPTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_mmio_addr,
  input  logic [DATA_WIDTH-1:0] i_mmio_data,
  input  logic                  i_mmio_wr_valid,
  output logic                  o_mmio_wr_ready,
  output logic [DATA_WIDTH-1:0] o_mmio_data,
  output logic                  o_mmio_rd_valid,
  input  logic                  i_mmio_rd_ready,
  output logic                  o_tx,
  input  logic                  i_rx,
  output logic                  o_irq,
  output logic [4:0]            o_dbg_state  // {rx_state, tx_state, rd_state}
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_RXDATA  = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_DIVISOR = 2'd3;

  typedef enum logic       {RD_IDLE, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rd_state_t rd_state, rd_next;
  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic        hit, rd_start, rd_clear, push, pop, status_wr, div_wr;
  logic [1:0]  offset, rd_off;
  logic [DATA_WIDTH-1:0] rdata;
  logic [15:0] divisor, eff_div;
  logic        rx_valid, overrun, frame_err;
  logic [7:0]  rx_byte;
  logic        unused_bits;

  // TX FIFO
  logic [7:0]  mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic        tx_full, tx_empty, tx_busy;

  // TX datapath
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;
  logic        tx_done;

  // RX datapath
  logic        rx_s1, rx_s2, rx_fall;
  logic [15:0] rx_cnt, rx_div, rx_half;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rx_done, rx_end, rx_load, rx_ovr, rx_ferr;

  assign hit      = (i_mmio_addr[31:4] == BASE_ADDR[31:4]) && (i_mmio_addr[1:0] == 2'b00);
  assign offset   = i_mmio_addr[3:2];
  assign tx_full  = (count == (AW+1)'(TX_DEPTH));
  assign tx_empty = (count == '0);
  assign tx_busy  = (tx_state != TX_IDLE);
  assign eff_div  = (divisor == 16'd0) ? 16'd1 : divisor;

  assign o_mmio_wr_ready = !i_rst && i_mmio_wr_valid && hit && (rd_state == RD_IDLE)
                           && !((offset == OFF_TXDATA) && tx_full);
  assign push      = o_mmio_wr_ready && (offset == OFF_TXDATA);
  assign status_wr = o_mmio_wr_ready && (offset == OFF_STATUS);
  assign div_wr    = o_mmio_wr_ready && (offset == OFF_DIVISOR);
  assign rd_start  = i_mmio_rd_ready && hit && !i_mmio_wr_valid;
  assign rd_clear  = (rd_state == RD_RESP) && i_mmio_rd_ready && (rd_off == OFF_RXDATA);
  assign o_mmio_rd_valid = (rd_state == RD_RESP);
  assign o_irq       = rx_valid;
  assign o_dbg_state = {rx_state, tx_state, rd_state};
  assign unused_bits = ^i_mmio_data;

  // Register read mux for the currently addressed offset
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_RXDATA:  rdata[8:0]  = {rx_valid, rx_byte};
      OFF_STATUS:  rdata[5:0]  = {tx_busy, frame_err, overrun, rx_valid, tx_empty, tx_full};
      OFF_DIVISOR: rdata[15:0] = divisor;
      default:     rdata       = '0;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) rd_state <= RD_IDLE;
    else       rd_state <= rd_next;
  end

  // Read FSM next state: a response lasts exactly one cycle
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (rd_start) rd_next = RD_RESP;
      RD_RESP: rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // Latch read data and the offset whose side effect applies on completion
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mmio_data <= '0;
      rd_off      <= 2'd0;
    end else if ((rd_state == RD_IDLE) && rd_start) begin
      o_mmio_data <= rdata;
      rd_off      <= offset;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_mmio_data[7:0];
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop     = (tx_state == TX_IDLE) && !tx_empty;
  assign tx_done = (tx_cnt == tx_div - 16'd1);

  // TX FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  // TX FSM next state
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (!tx_empty) tx_next = TX_START;
      TX_START: if (tx_done) tx_next = TX_DATA;
      TX_DATA:  if (tx_done && (tx_idx == 3'd7)) tx_next = TX_STOP;
      TX_STOP:  if (tx_done) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX bit timing and shifter; the divisor is captured once per frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tx     <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= 16'd1;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (pop) begin
          tx_shift <= mem[rd_ptr];
          tx_div   <= eff_div;
          tx_cnt   <= '0;
          o_tx     <= 1'b0;
        end
        TX_START: if (tx_done) begin
          tx_cnt <= '0;
          tx_idx <= '0;
          o_tx   <= tx_shift[0];
        end else tx_cnt <= tx_cnt + 16'd1;
        TX_DATA: if (tx_done) begin
          tx_cnt <= '0;
          if (tx_idx == 3'd7) o_tx <= 1'b1;
          else begin
            tx_idx   <= tx_idx + 3'd1;
            tx_shift <= tx_shift >> 1;
            o_tx     <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        TX_STOP: if (tx_done) tx_cnt <= '0;
                 else tx_cnt <= tx_cnt + 16'd1;
        default: tx_cnt <= '0;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous RX line
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
    end
  end

  assign rx_fall = rx_s2 && !rx_s1;
  assign rx_half = rx_div >> 1;
  assign rx_done = (rx_cnt == rx_div - 16'd1);
  assign rx_end  = (rx_state == RX_STOP) && rx_done;
  // A read-clear landing with a new byte frees the buffer, so the byte loads
  assign rx_load = rx_end && rx_s2 && !(rx_valid && !rd_clear);
  assign rx_ovr  = rx_end && rx_s2 && rx_valid && !rd_clear;
  assign rx_ferr = rx_end && !rx_s2;

  // RX FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // RX FSM next state; a start bit that is high at mid-bit is a glitch
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_cnt == rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_done && (rx_idx == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_done) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX sample timing and shifter (LSB first)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_cnt   <= '0;
      rx_div   <= 16'd1;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_fall) begin
          rx_cnt <= '0;
          rx_div <= eff_div;
        end
        RX_START: if (rx_cnt == rx_half) begin
          rx_cnt <= '0;
          rx_idx <= '0;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_DATA: if (rx_done) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_idx   <= rx_idx + 3'd1;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_STOP: if (rx_done) rx_cnt <= '0;
                 else rx_cnt <= rx_cnt + 16'd1;
        default: rx_cnt <= '0;
      endcase
    end
  end

  // Status flags, RX buffer and divisor register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      divisor   <= CLK_DIV;
    end else begin
      if (rx_load) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_clear) rx_valid <= 1'b0;
      if (rx_ovr) overrun <= 1'b1;
      else if (status_wr && i_mmio_data[3]) overrun <= 1'b0;
      if (rx_ferr) frame_err <= 1'b1;
      else if (status_wr && i_mmio_data[4]) frame_err <= 1'b0;
      if (div_wr) divisor <= i_mmio_data[15:0];
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Testbench for mmio_uart: register table, TX/RX frames and handshake corners.
module tb_mmio_uart;

  localparam logic [31:0] BASE  = 32'hFFFF0000;
  localparam logic [31:0] A_TX  = BASE + 32'd0;
  localparam logic [31:0] A_RX  = BASE + 32'd4;
  localparam logic [31:0] A_ST  = BASE + 32'd8;
  localparam logic [31:0] A_DIV = BASE + 32'd12;

  logic        i_clk, i_rst;
  logic [31:0] i_mmio_addr, i_mmio_data, o_mmio_data;
  logic        i_mmio_wr_valid, o_mmio_wr_ready, o_mmio_rd_valid, i_mmio_rd_ready;
  logic        o_tx, i_rx, o_irq;
  logic [4:0]  o_dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  bit          tx_mon_en = 1'b1;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;  // write data, or expected read data
  } vec_t;
  vec_t tbl[14];

  mmio_uart dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_mmio_addr(i_mmio_addr), .i_mmio_data(i_mmio_data),
    .i_mmio_wr_valid(i_mmio_wr_valid), .o_mmio_wr_ready(o_mmio_wr_ready),
    .o_mmio_data(o_mmio_data), .o_mmio_rd_valid(o_mmio_rd_valid),
    .i_mmio_rd_ready(i_mmio_rd_ready),
    .o_tx(o_tx), .i_rx(i_rx), .o_irq(o_irq), .o_dbg_state(o_dbg_state)
  );

  // Clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Read scoreboard: each response pops the oldest expected value
  always @(negedge i_clk) begin
    if (o_mmio_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got rd_valid with data 0x%0h, none expected", o_mmio_data);
      end else begin
        check("rd_data", o_mmio_data, exp_q.pop_front());
      end
    end
  end

  // TX scoreboard: capture 40 cycles (DIVISOR=4) from each start bit
  initial begin
    logic s [40];
    logic [7:0] eb, gb;
    int bad;
    logic e;
    forever begin
      @(negedge i_clk);
      if (tx_mon_en && !i_rst && o_tx === 1'b0) begin
        s[0] = o_tx;
        for (int i = 1; i < 40; i++) begin
          @(negedge i_clk);
          s[i] = o_tx;
        end
        if (tx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected: frame seen with no byte queued");
        end else begin
          eb = tx_q.pop_front();
          bad = 0;
          for (int i = 0; i < 40; i++) begin
            if (i < 4) e = 1'b0;
            else if (i >= 36) e = 1'b1;
            else e = eb[(i-4)/4];
            if (s[i] !== e) bad++;
          end
          for (int b = 0; b < 8; b++) gb[b] = s[4 + 4*b + 2];
          check("tx_byte", gb, eb);
          check("tx_bit_timing_errors", bad, 0);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic mmio_read(input logic [31:0] addr, input logic [31:0] exp, input bit abort);
    i_mmio_wr_valid = 1'b0;
    i_mmio_addr     = addr;
    i_mmio_rd_ready = 1'b1;
    exp_q.push_back(exp);
    @(negedge i_clk);
    check("rd_latency", o_mmio_rd_valid, 1);
    if (abort) i_mmio_rd_ready = 1'b0;
    @(negedge i_clk);
    i_mmio_rd_ready = 1'b0;
  endtask

  task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data, output int waited);
    i_mmio_rd_ready = 1'b0;
    i_mmio_addr     = addr;
    i_mmio_data     = data;
    i_mmio_wr_valid = 1'b1;
    waited = 0;
    #1;
    while (o_mmio_wr_ready !== 1'b1 && waited < 200) begin
      @(negedge i_clk);
      #1;
      waited++;
    end
    if (o_mmio_wr_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wr_timeout: addr 0x%0h never acknowledged", addr);
      @(negedge i_clk);
    end else begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    i_mmio_wr_valid = 1'b0;
  endtask

  task automatic tx_send(input logic [7:0] b, input int exp_wait);
    int w;
    tx_q.push_back(b);
    mmio_write(A_TX, {24'd0, b}, w);
    check("tx_wr_wait", w, exp_wait);
  endtask

  // Drive one frame at 4 cycles per bit, then idle high
  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_rx = f[i];
      repeat (4) @(negedge i_clk);
    end
    i_rx = 1'b1;
    repeat (6) @(negedge i_clk);
  endtask

  initial begin
    int w, cnt;
    i_rst = 1'b1;
    i_mmio_addr = A_DIV;
    i_mmio_data = 32'd0;
    i_mmio_wr_valid = 1'b1;
    i_mmio_rd_ready = 1'b0;
    i_rx = 1'b1;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_tx", o_tx, 1);
    check("rst_rd_valid", o_mmio_rd_valid, 0);
    check("rst_rd_data", o_mmio_data, 0);
    check("rst_irq", o_irq, 0);
    check("rst_wr_ready", o_mmio_wr_ready, 0);
    i_mmio_wr_valid = 1'b0;
    i_rst = 1'b0;
    @(negedge i_clk);

    // Register table
    tbl[0]  = '{1'b0, A_ST,  32'h02};
    tbl[1]  = '{1'b0, A_DIV, 32'd868};
    tbl[2]  = '{1'b0, A_TX,  32'h0};
    tbl[3]  = '{1'b0, A_RX,  32'h0};
    tbl[4]  = '{1'b1, A_DIV, 32'h12340000};
    tbl[5]  = '{1'b0, A_DIV, 32'h0};
    tbl[6]  = '{1'b1, A_DIV, 32'hABCD0007};
    tbl[7]  = '{1'b0, A_DIV, 32'h7};
    tbl[8]  = '{1'b1, A_RX,  32'hFF};
    tbl[9]  = '{1'b0, A_RX,  32'h0};
    tbl[10] = '{1'b1, A_ST,  32'h18};
    tbl[11] = '{1'b0, A_ST,  32'h02};
    tbl[12] = '{1'b1, A_DIV, 32'h4};
    tbl[13] = '{1'b0, A_DIV, 32'h4};
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].is_wr) begin
        mmio_write(tbl[i].addr, tbl[i].data, w);
        check("wr_ack_wait", w, 0);
      end else begin
        mmio_read(tbl[i].addr, tbl[i].data, 1'b0);
      end
    end

    // Single frame 0xA5; busy spans 40 cycles after the pop
    tx_send(8'hA5, 0);
    repeat (40) @(negedge i_clk);
    mmio_read(A_ST, 32'h22, 1'b0);
    mmio_read(A_ST, 32'h02, 1'b0);

    // Six back-to-back bytes: FIFO fills after the first pop, the sixth stalls
    tx_send(8'h01, 0);
    tx_send(8'h80, 0);
    tx_send(8'h3C, 0);
    tx_send(8'hFF, 0);
    tx_send(8'h00, 0);
    tx_send(8'h5A, 38);
    for (int t = 0; t < 600 && tx_q.size() != 0; t++) @(negedge i_clk);
    check("tx_drain", tx_q.size(), 0);
    repeat (4) @(negedge i_clk);

    // RX byte and read-clear
    rx_send(8'h3C, 1'b1);
    check("rx_irq_set", o_irq, 1);
    mmio_read(A_RX, 32'h13C, 1'b0);
    check("rx_irq_clr", o_irq, 0);
    mmio_read(A_RX, 32'h03C, 1'b0);

    // Short low pulse is rejected as a glitch
    i_rx = 1'b0;
    @(negedge i_clk);
    i_rx = 1'b1;
    repeat (12) @(negedge i_clk);
    mmio_read(A_ST, 32'h02, 1'b0);

    // Overrun, write-1-to-clear, then framing error with a byte pending
    rx_send(8'h55, 1'b1);
    rx_send(8'hAA, 1'b1);
    mmio_read(A_ST, 32'h0E, 1'b0);
    mmio_write(A_ST, 32'h08, w);
    mmio_read(A_ST, 32'h06, 1'b0);
    rx_send(8'h99, 1'b0);
    mmio_read(A_ST, 32'h16, 1'b0);
    mmio_read(A_RX, 32'h155, 1'b0);
    mmio_write(A_ST, 32'h10, w);
    mmio_read(A_ST, 32'h02, 1'b0);

    // Abandoned read leaves rx_valid set
    rx_send(8'h77, 1'b1);
    mmio_read(A_RX, 32'h177, 1'b1);
    mmio_read(A_RX, 32'h177, 1'b0);
    mmio_read(A_RX, 32'h077, 1'b0);

    // Write and read requested together: write wins, no read starts
    i_mmio_addr = A_DIV;
    i_mmio_data = 32'd5;
    i_mmio_wr_valid = 1'b1;
    i_mmio_rd_ready = 1'b1;
    #1;
    check("wr_priority_ready", o_mmio_wr_ready, 1);
    @(negedge i_clk);
    check("wr_priority_no_read", o_mmio_rd_valid, 0);
    i_mmio_wr_valid = 1'b0;
    i_mmio_rd_ready = 1'b0;
    @(negedge i_clk);
    mmio_read(A_DIV, 32'd5, 1'b0);
    mmio_write(A_DIV, 32'd4, w);

    // Address misses: out of window and misaligned
    i_mmio_addr = 32'hFFFF0010;
    i_mmio_wr_valid = 1'b1;
    #1;
    check("miss_wr_ready", o_mmio_wr_ready, 0);
    i_mmio_wr_valid = 1'b0;
    i_mmio_rd_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      if (o_mmio_rd_valid !== 1'b0) cnt++;
    end
    i_mmio_addr = BASE + 32'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      if (o_mmio_rd_valid !== 1'b0) cnt++;
    end
    check("miss_rd_valid_cycles", cnt, 0);
    i_mmio_rd_ready = 1'b0;
    @(negedge i_clk);

    // Reset in the middle of a TX frame
    tx_mon_en = 1'b0;
    mmio_write(A_TX, 32'h00, w);
    repeat (10) @(negedge i_clk);
    check("tx_mid_frame_low", o_tx, 0);
    i_rst = 1'b1;
    i_mmio_addr = A_DIV;
    i_mmio_data = 32'd9;
    i_mmio_wr_valid = 1'b1;
    @(posedge i_clk);
    #1;
    check("rst_mid_tx", o_tx, 1);
    check("rst_mid_wr_ready", o_mmio_wr_ready, 0);
    @(negedge i_clk);
    i_mmio_wr_valid = 1'b0;
    i_rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1) cnt++;
    end
    check("post_rst_tx_idle_low_cycles", cnt, 0);
    mmio_read(A_ST, 32'h02, 1'b0);
    mmio_read(A_DIV, 32'd868, 1'b0);

    repeat (5) @(negedge i_clk);
    check("rd_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
